// File: rtl/axi_mem_responder_if.sv
// axi_pkg: shared types and response codes for the memory responder.
// axi_mem_responder_if: bundles the read-request, write-beat, read-response
// and write-response channels. The "master" modport drives requests and
// response readies. The "slave" modport is the responder side.
package axi_pkg;
    typedef logic [1:0]  id_t;
    typedef logic [15:0] addr_t;
    typedef logic [15:0] data_t;
    typedef logic [1:0]  strb_t;
    typedef logic [1:0]  resp_t;

    localparam resp_t RESP_OKAY   = 2'd0;
    localparam resp_t RESP_EXOKAY = 2'd1;
    localparam resp_t RESP_DECERR = 2'd3;

    typedef struct packed {
        id_t   id;
        addr_t addr;
        logic  lock;
    } rd_req_t;

    typedef struct packed {
        id_t   id;
        addr_t addr;
        data_t data;
        strb_t strb;
        logic  last;
        logic  lock;
    } wr_req_t;
endpackage

interface axi_mem_responder_if;
    import axi_pkg::*;

    rd_req_t rd_req_i;
    logic    rd_req_valid_i;
    logic    rd_req_ready_o;

    wr_req_t wr_req_i;
    logic    wr_req_valid_i;
    logic    wr_req_ready_o;

    id_t     r_id_o;
    data_t   r_data_o;
    resp_t   r_resp_o;
    logic    r_last_o;
    logic    r_valid_o;
    logic    r_ready_i;

    id_t     b_id_o;
    resp_t   b_resp_o;
    logic    b_valid_o;
    logic    b_ready_i;

    modport master (
        output rd_req_i, rd_req_valid_i, input rd_req_ready_o,
        output wr_req_i, wr_req_valid_i, input wr_req_ready_o,
        input  r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o, output r_ready_i,
        input  b_id_o, b_resp_o, b_valid_o, output b_ready_i
    );

    modport slave (
        input  rd_req_i, rd_req_valid_i, output rd_req_ready_o,
        input  wr_req_i, wr_req_valid_i, output wr_req_ready_o,
        output r_id_o, r_data_o, r_resp_o, r_last_o, r_valid_o, input r_ready_i,
        output b_id_o, b_resp_o, b_valid_o, input b_ready_i
    );
endinterface

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-bank word memory behind a simplified AXI-like
// read/write interface. It serves addr[15:12] == BANK_ID and indexes words
// by addr[11:1]. Requests in IDLE are arbitrated round-robin (read first
// after reset). Reads answer one cycle after acceptance. Write bursts answer
// one cycle after the last beat.
// Ports: clk, rst (sync, active-high), bus (axi_mem_responder_if.slave).
// Optional macro AXI_MEM_RESPONDER_EXCL_MON_EN adds a single-entry exclusive
// monitor {valid, id, word}.
//
// state     | meaning
// S_IDLE    | arbitrate between read request and first write beat
// S_WRITE   | accepting remaining beats of a write burst
// S_WR_RESP | B response pending
// S_RD_RESP | R response pending
module axi_mem_responder
    import axi_pkg::*;
#(
    parameter logic [3:0] BANK_ID   = 4'h0,
    parameter int         MEM_WORDS = 2048
) (
    input logic            clk,
    input logic            rst,
    axi_mem_responder_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    typedef logic [AW-1:0] word_t;
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WR_RESP, S_RD_RESP} state_t;

    state_t state_q, state_d;
    logic   rr_q, rr_d;          // 1: write wins the next contention
    id_t    r_id_q, r_id_d;
    data_t  r_data_q, r_data_d;
    resp_t  r_resp_q, r_resp_d;
    logic   r_last_q, r_last_d;
    logic   r_valid_q, r_valid_d;
    id_t    b_id_q, b_id_d;
    resp_t  b_resp_q, b_resp_d;
    logic   b_valid_q, b_valid_d;
    logic   wr_ok_q, wr_ok_d;    // burst decoded and not a failed exclusive

    logic [15:0] mem_q [MEM_WORDS];

    word_t rd_word, wr_word;
    logic  rd_hit, wr_hit, grant_rd, grant_wr;
    logic  rd_ready, wr_ready, mem_we;

`ifdef AXI_MEM_RESPONDER_EXCL_MON_EN
    logic  res_valid_q, res_valid_d;
    id_t   res_id_q, res_id_d;
    word_t res_word_q, res_word_d;
`endif

    assign rd_word  = bus.rd_req_i.addr[AW:1];
    assign wr_word  = bus.wr_req_i.addr[AW:1];
    assign rd_hit   = (bus.rd_req_i.addr[15:12] == BANK_ID);
    assign wr_hit   = (bus.wr_req_i.addr[15:12] == BANK_ID);
    assign grant_rd = bus.rd_req_valid_i && (!bus.wr_req_valid_i || !rr_q);
    assign grant_wr = bus.wr_req_valid_i && (!bus.rd_req_valid_i || rr_q);

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        r_id_d    = r_id_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        r_last_d  = r_last_q;
        r_valid_d = r_valid_q;
        b_id_d    = b_id_q;
        b_resp_d  = b_resp_q;
        b_valid_d = b_valid_q;
        wr_ok_d   = wr_ok_q;
        rd_ready  = 1'b0;
        wr_ready  = 1'b0;
        mem_we    = 1'b0;
`ifdef AXI_MEM_RESPONDER_EXCL_MON_EN
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_word_d  = res_word_q;
`endif
        case (state_q)
            S_IDLE: begin
                rd_ready = grant_rd;
                wr_ready = grant_wr;
                if (grant_rd) begin
                    rr_d      = 1'b1;
                    state_d   = S_RD_RESP;
                    r_valid_d = 1'b1;
                    r_last_d  = 1'b1;
                    r_id_d    = bus.rd_req_i.id;
                    if (rd_hit) begin
                        r_data_d = mem_q[rd_word];
                        r_resp_d = RESP_OKAY;
`ifdef AXI_MEM_RESPONDER_EXCL_MON_EN
                        if (bus.rd_req_i.lock) begin
                            res_valid_d = 1'b1;
                            res_id_d    = bus.rd_req_i.id;
                            res_word_d  = rd_word;
                            r_resp_d    = RESP_EXOKAY;
                        end
`endif
                    end else begin
                        r_data_d = '0;
                        r_resp_d = RESP_DECERR;
                    end
                end else if (grant_wr) begin
                    rr_d   = 1'b0;
                    b_id_d = bus.wr_req_i.id;
                    if (!wr_hit) begin
                        wr_ok_d  = 1'b0;
                        b_resp_d = RESP_DECERR;
                    end else begin
                        wr_ok_d  = 1'b1;
                        b_resp_d = RESP_OKAY;
`ifdef AXI_MEM_RESPONDER_EXCL_MON_EN
                        if (bus.wr_req_i.lock) begin
                            if (res_valid_q && res_id_q == bus.wr_req_i.id &&
                                res_word_q == wr_word) begin
                                b_resp_d    = RESP_EXOKAY;
                                res_valid_d = 1'b0;
                            end else begin
                                wr_ok_d = 1'b0;
                            end
                        end
`endif
                    end
                    mem_we = wr_ok_d;
                    if (bus.wr_req_i.last) begin
                        state_d   = S_WR_RESP;
                        b_valid_d = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wr_ready = 1'b1;
                if (bus.wr_req_valid_i) begin
                    mem_we = wr_ok_q;
                    if (bus.wr_req_i.last) begin
                        state_d   = S_WR_RESP;
                        b_valid_d = 1'b1;
                    end
                end
            end
            S_WR_RESP: begin
                if (bus.b_ready_i) begin
                    b_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_RD_RESP: begin
                if (bus.r_ready_i) begin
                    r_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef AXI_MEM_RESPONDER_EXCL_MON_EN
        // Any write actually landing on the reserved word kills the reservation.
        if (mem_we && res_valid_q && res_word_q == wr_word)
            res_valid_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rr_q      <= 1'b0;
            r_id_q    <= '0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            r_last_q  <= 1'b0;
            r_valid_q <= 1'b0;
            b_id_q    <= '0;
            b_resp_q  <= '0;
            b_valid_q <= 1'b0;
            wr_ok_q   <= 1'b0;
`ifdef AXI_MEM_RESPONDER_EXCL_MON_EN
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_word_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            r_id_q    <= r_id_d;
            r_data_q  <= r_data_d;
            r_resp_q  <= r_resp_d;
            r_last_q  <= r_last_d;
            r_valid_q <= r_valid_d;
            b_id_q    <= b_id_d;
            b_resp_q  <= b_resp_d;
            b_valid_q <= b_valid_d;
            wr_ok_q   <= wr_ok_d;
`ifdef AXI_MEM_RESPONDER_EXCL_MON_EN
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_word_q  <= res_word_d;
`endif
        end
    end

    // Memory is never reset; a beat coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            if (bus.wr_req_i.strb[0]) mem_q[wr_word][7:0]  <= bus.wr_req_i.data[7:0];
            if (bus.wr_req_i.strb[1]) mem_q[wr_word][15:8] <= bus.wr_req_i.data[15:8];
        end
    end

    assign bus.rd_req_ready_o = rd_ready;
    assign bus.wr_req_ready_o = wr_ready;
    assign bus.r_id_o         = r_id_q;
    assign bus.r_data_o       = r_data_q;
    assign bus.r_resp_o       = r_resp_q;
    assign bus.r_last_o       = r_last_q;
    assign bus.r_valid_o      = r_valid_q;
    assign bus.b_id_o         = b_id_q;
    assign bus.b_resp_o       = b_resp_q;
    assign bus.b_valid_o      = b_valid_q;

    logic unused_bits;
    assign unused_bits = ^{bus.rd_req_i.addr[0], bus.wr_req_i.addr[0],
                           bus.rd_req_i.lock, bus.wr_req_i.lock};
endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;
    import axi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_mem_responder_if bus();

    axi_mem_responder #(.BANK_ID(4'h0), .MEM_WORDS(2048)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] model_mem [64];

    function automatic void model_write(input int word, input logic [15:0] d, input logic [1:0] s);
        if (s[0]) model_mem[word][7:0]  = d[7:0];
        if (s[1]) model_mem[word][15:8] = d[15:8];
    endfunction

    task automatic do_read(input logic [1:0] id, input logic [15:0] addr, input logic lock,
                           output logic [15:0] data, output logic [1:0] resp,
                           output logic [1:0] rid, output logic last,
                           output logic lat_ok, output logic to);
        int n;
        n = 0; to = 1'b0; data = '0; resp = '0; rid = '0; last = 1'b0; lat_ok = 1'b0;
        bus.rd_req_i.id = id; bus.rd_req_i.addr = addr; bus.rd_req_i.lock = lock;
        bus.rd_req_valid_i = 1'b1;
        @(negedge clk);
        while (!bus.rd_req_ready_o && n < 20) begin @(negedge clk); n++; end
        if (!bus.rd_req_ready_o) begin to = 1'b1; bus.rd_req_valid_i = 1'b0; return; end
        @(posedge clk); #1;
        bus.rd_req_valid_i = 1'b0;
        lat_ok = bus.r_valid_o; data = bus.r_data_o; resp = bus.r_resp_o;
        rid = bus.r_id_o; last = bus.r_last_o;
        bus.r_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.r_ready_i = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] id, input logic [15:0] base, input int nb,
                            input logic [15:0] d [4], input logic [1:0] s [4], input logic lock,
                            output logic [1:0] bresp, output logic [1:0] bid,
                            output logic lat_ok, output logic to);
        int n;
        to = 1'b0; bresp = '0; bid = '0; lat_ok = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bus.wr_req_i.id   = id;
            bus.wr_req_i.addr = base + 16'(2 * i);
            bus.wr_req_i.data = d[i];
            bus.wr_req_i.strb = s[i];
            bus.wr_req_i.last = (i == nb - 1);
            bus.wr_req_i.lock = lock;
            bus.wr_req_valid_i = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.wr_req_ready_o && n < 20) begin @(negedge clk); n++; end
            if (!bus.wr_req_ready_o) begin to = 1'b1; bus.wr_req_valid_i = 1'b0; return; end
            @(posedge clk); #1;
        end
        bus.wr_req_valid_i = 1'b0;
        lat_ok = bus.b_valid_o; bresp = bus.b_resp_o; bid = bus.b_id_o;
        bus.b_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.b_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.r_valid_o !== 1'b0 || bus.b_valid_o !== 1'b0) begin
            errors++; $display("FAIL reset_valid got r=%b b=%b want 0 0", bus.r_valid_o, bus.b_valid_o);
        end
        checks++;
        if ({bus.r_id_o, bus.r_data_o, bus.r_resp_o, bus.r_last_o} !== 21'h0) begin
            errors++; $display("FAIL reset_r_payload got %h want 0", {bus.r_id_o, bus.r_data_o, bus.r_resp_o, bus.r_last_o});
        end
        checks++;
        if ({bus.b_id_o, bus.b_resp_o} !== 4'h0) begin
            errors++; $display("FAIL reset_b_payload got %h want 0", {bus.b_id_o, bus.b_resp_o});
        end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        logic [15:0] d [4]; logic [1:0] s [4];
        logic [1:0] br, bi; logic lat, to;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin d[i] = 16'($urandom); s[i] = 2'b11; end
            do_write(2'(k), 16'(8 * k), 4, d, s, 1'b0, br, bi, lat, to);
            for (int i = 0; i < 4; i++) model_write(4 * k + i, d[i], s[i]);
            checks++;
            if (to || !lat || br !== RESP_OKAY || bi !== 2'(k)) begin
                errors++; $display("FAIL fill_b got to=%b lat=%b resp=%0d id=%0d want 0 1 0 %0d", to, lat, br, bi, k);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] d [4]; logic [1:0] s [4];
        logic [1:0] br, bi, rr, ri; logic [15:0] rd; logic lat, to, rl;
        d[0] = 16'hBEEF; s[0] = 2'b11;
        for (int i = 1; i < 4; i++) begin d[i] = '0; s[i] = '0; end
        do_write(2'd1, 16'h0010, 1, d, s, 1'b0, br, bi, lat, to);
        model_write(8, d[0], s[0]);
        checks++;
        if (to || !lat || br !== RESP_OKAY || bi !== 2'd1) begin
            errors++; $display("FAIL basic_b got to=%b lat=%b resp=%0d id=%0d want 0 1 0 1", to, lat, br, bi);
        end
        do_read(2'd0, 16'h0010, 1'b0, rd, rr, ri, rl, lat, to);
        checks++;
        if (to || !lat || rd !== 16'hBEEF || rl !== 1'b1 || rr !== RESP_OKAY) begin
            errors++; $display("FAIL basic_r got to=%b lat=%b data=%h last=%b resp=%0d want 0 1 beef 1 0", to, lat, rd, rl, rr);
        end
        d[0] = 16'h1234; s[0] = 2'b01;
        do_write(2'd1, 16'h0010, 1, d, s, 1'b0, br, bi, lat, to);
        model_write(8, d[0], s[0]);
        do_read(2'd2, 16'h0010, 1'b0, rd, rr, ri, rl, lat, to);
        checks++;
        if (to || rd !== 16'hBE34 || ri !== 2'd2) begin
            errors++; $display("FAIL strb_merge got to=%b data=%h id=%0d want 0 be34 2", to, rd, ri);
        end
    endtask

    task automatic test_random();
        logic [15:0] d [4]; logic [1:0] s [4];
        logic [1:0] br, bi, rr, ri, id; logic [15:0] rd; logic lat, to, rl, lk;
        int w, nb;
        for (int it = 0; it < 40; it++) begin
            id = 2'($urandom);
`ifdef AXI_MEM_RESPONDER_EXCL_MON_EN
            lk = 1'b0;
`else
            lk = 1'($urandom);
`endif
            if ($urandom_range(0, 1) == 0) begin
                w = $urandom_range(0, 63);
                do_read(id, 16'(2 * w), lk, rd, rr, ri, rl, lat, to);
                checks++;
                if (to || !lat || rd !== model_mem[w] || rr !== RESP_OKAY || ri !== id || rl !== 1'b1) begin
                    errors++; $display("FAIL rand_read w=%0d got to=%b lat=%b data=%h resp=%0d id=%0d last=%b want data=%h resp=0 id=%0d",
                                       w, to, lat, rd, rr, ri, rl, model_mem[w], id);
                end
            end else begin
                w = $urandom_range(0, 60);
                nb = $urandom_range(1, 4);
                for (int i = 0; i < 4; i++) begin d[i] = 16'($urandom); s[i] = 2'($urandom); end
                do_write(id, 16'(2 * w), nb, d, s, lk, br, bi, lat, to);
                for (int i = 0; i < nb; i++) model_write(w + i, d[i], s[i]);
                checks++;
                if (to || !lat || br !== RESP_OKAY || bi !== id) begin
                    errors++; $display("FAIL rand_write got to=%b lat=%b resp=%0d id=%0d want 0 1 0 %0d", to, lat, br, bi, id);
                end
            end
        end
    endtask

    task automatic test_decerr();
        logic [15:0] d [4]; logic [1:0] s [4];
        logic [1:0] br, bi, rr, ri; logic [15:0] rd; logic lat, to, rl;
        for (int i = 0; i < 4; i++) begin d[i] = ~model_mem[8 + i]; s[i] = 2'b11; end
        do_write(2'd3, 16'h1010, 3, d, s, 1'b0, br, bi, lat, to);
        checks++;
        if (to || !lat || br !== RESP_DECERR || bi !== 2'd3) begin
            errors++; $display("FAIL decerr_b got to=%b lat=%b resp=%0d id=%0d want 0 1 3 3", to, lat, br, bi);
        end
        for (int i = 0; i < 3; i++) begin
            do_read(2'd0, 16'(16'h0010 + 2 * i), 1'b0, rd, rr, ri, rl, lat, to);
            checks++;
            if (to || rd !== model_mem[8 + i]) begin
                errors++; $display("FAIL decerr_nowrite w=%0d got %h want %h", 8 + i, rd, model_mem[8 + i]);
            end
        end
        do_read(2'd1, 16'h2000, 1'b0, rd, rr, ri, rl, lat, to);
        checks++;
        if (to || !lat || rd !== 16'h0000 || rr !== RESP_DECERR || ri !== 2'd1 || rl !== 1'b1) begin
            errors++; $display("FAIL decerr_r got to=%b lat=%b data=%h resp=%0d id=%0d want 0 1 0000 3 1", to, lat, rd, rr, ri);
        end
    endtask

    task automatic test_arbiter();
        logic prefer_write;
        logic [15:0] exp_r, wdat;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        prefer_write = 1'b0;
        @(negedge clk);
        bus.rd_req_i.id = 2'd3; bus.rd_req_i.addr = 16'h0010; bus.rd_req_i.lock = 1'b0;
        bus.rd_req_valid_i = 1'b1;
        wdat = 16'($urandom);
        bus.wr_req_i.id = 2'd2; bus.wr_req_i.addr = 16'h0030; bus.wr_req_i.data = wdat;
        bus.wr_req_i.strb = 2'b11; bus.wr_req_i.last = 1'b1; bus.wr_req_i.lock = 1'b0;
        bus.wr_req_valid_i = 1'b1;
        #1;
        checks++;
        if (bus.rd_req_ready_o !== !prefer_write || bus.wr_req_ready_o !== prefer_write) begin
            errors++; $display("FAIL arb_first got rd=%b wr=%b want rd=1 wr=0", bus.rd_req_ready_o, bus.wr_req_ready_o);
        end
        prefer_write = 1'b1;
        exp_r = model_mem[8];
        @(posedge clk); #1;
        bus.rd_req_valid_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.r_valid_o !== 1'b1 || bus.r_data_o !== exp_r || bus.r_id_o !== 2'd3 ||
                bus.r_resp_o !== RESP_OKAY || bus.r_last_o !== 1'b1) begin
                errors++; $display("FAIL r_hold c=%0d got v=%b data=%h id=%0d resp=%0d want 1 %h 3 0",
                                   c, bus.r_valid_o, bus.r_data_o, bus.r_id_o, bus.r_resp_o, exp_r);
            end
            checks++;
            if (bus.wr_req_ready_o !== 1'b0) begin
                errors++; $display("FAIL wr_ready_in_rresp got %b want 0", bus.wr_req_ready_o);
            end
            @(posedge clk); #1;
        end
        bus.r_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.r_ready_i = 1'b0;
        bus.rd_req_i.id = 2'd1; bus.rd_req_i.addr = 16'h0012;
        bus.rd_req_valid_i = 1'b1;
        #1;
        checks++;
        if (bus.wr_req_ready_o !== prefer_write || bus.rd_req_ready_o !== !prefer_write) begin
            errors++; $display("FAIL arb_second got rd=%b wr=%b want rd=0 wr=1", bus.rd_req_ready_o, bus.wr_req_ready_o);
        end
        prefer_write = 1'b0;
        @(posedge clk); #1;
        bus.wr_req_valid_i = 1'b0;
        model_write(24, wdat, 2'b11);
        checks++;
        if (bus.b_valid_o !== 1'b1 || bus.b_id_o !== 2'd2 || bus.b_resp_o !== RESP_OKAY || bus.rd_req_ready_o !== 1'b0) begin
            errors++; $display("FAIL arb_b got v=%b id=%0d resp=%0d rdy=%b want 1 2 0 0", bus.b_valid_o, bus.b_id_o, bus.b_resp_o, bus.rd_req_ready_o);
        end
        bus.b_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.b_ready_i = 1'b0;
        bus.wr_req_i.id = 2'd0; bus.wr_req_i.addr = 16'h0032;
        bus.wr_req_valid_i = 1'b1;
        #1;
        checks++;
        if (bus.rd_req_ready_o !== !prefer_write || bus.wr_req_ready_o !== prefer_write) begin
            errors++; $display("FAIL arb_third got rd=%b wr=%b want rd=1 wr=0", bus.rd_req_ready_o, bus.wr_req_ready_o);
        end
        @(posedge clk); #1;
        bus.rd_req_valid_i = 1'b0;
        bus.wr_req_valid_i = 1'b0;
        checks++;
        if (bus.r_valid_o !== 1'b1 || bus.r_data_o !== model_mem[9] || bus.r_id_o !== 2'd1) begin
            errors++; $display("FAIL arb_third_r got v=%b data=%h id=%0d want 1 %h 1", bus.r_valid_o, bus.r_data_o, bus.r_id_o, model_mem[9]);
        end
        bus.r_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.r_ready_i = 1'b0;
    endtask

    task automatic test_reset_midburst();
        logic [15:0] d [4];
        logic [1:0] rr, ri; logic [15:0] rd; logic lat, to, rl;
        int n;
        for (int i = 0; i < 4; i++) d[i] = ~model_mem[32 + i];
        for (int i = 0; i < 2; i++) begin
            bus.wr_req_i.id = 2'd1; bus.wr_req_i.addr = 16'(16'h0040 + 2 * i);
            bus.wr_req_i.data = d[i]; bus.wr_req_i.strb = 2'b11;
            bus.wr_req_i.last = 1'b0; bus.wr_req_i.lock = 1'b0;
            bus.wr_req_valid_i = 1'b1;
            n = 0;
            @(negedge clk);
            while (!bus.wr_req_ready_o && n < 20) begin @(negedge clk); n++; end
            checks++;
            if (!bus.wr_req_ready_o) begin
                errors++; $display("FAIL midburst_ready beat=%0d got 0 want 1", i);
            end
            @(posedge clk); #1;
        end
        bus.wr_req_valid_i = 1'b0;
        model_write(32, d[0], 2'b11);
        model_write(33, d[1], 2'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (bus.b_valid_o !== 1'b0) begin
                errors++; $display("FAIL midburst_no_b c=%0d got %b want 0", c, bus.b_valid_o);
            end
            @(posedge clk); #1;
        end
        bus.rd_req_i.id = 2'd0; bus.rd_req_i.addr = 16'h0040; bus.rd_req_i.lock = 1'b0;
        bus.rd_req_valid_i = 1'b1;
        #1;
        checks++;
        if (bus.rd_req_ready_o !== 1'b1) begin
            errors++; $display("FAIL midburst_idle got rd_ready=%b want 1", bus.rd_req_ready_o);
        end
        bus.rd_req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_read(2'd0, 16'(16'h0040 + 2 * i), 1'b0, rd, rr, ri, rl, lat, to);
            checks++;
            if (to || rd !== model_mem[32 + i]) begin
                errors++; $display("FAIL midburst_mem w=%0d got %h want %h", 32 + i, rd, model_mem[32 + i]);
            end
        end
    endtask

`ifdef AXI_MEM_RESPONDER_EXCL_MON_EN
    task automatic test_exclusive();
        logic [15:0] d [4]; logic [1:0] s [4];
        logic [1:0] br, bi, rr, ri; logic [15:0] rd; logic lat, to, rl;
        logic [15:0] first;
        do_read(2'd2, 16'h0020, 1'b1, rd, rr, ri, rl, lat, to);
        checks++;
        if (to || rr !== RESP_EXOKAY || rd !== model_mem[16]) begin
            errors++; $display("FAIL excl_read got resp=%0d data=%h want 1 %h", rr, rd, model_mem[16]);
        end
        first = ~model_mem[16];
        d[0] = first; s[0] = 2'b11;
        for (int i = 1; i < 4; i++) begin d[i] = '0; s[i] = '0; end
        do_write(2'd2, 16'h0020, 1, d, s, 1'b1, br, bi, lat, to);
        model_write(16, first, 2'b11);
        checks++;
        if (to || br !== RESP_EXOKAY) begin
            errors++; $display("FAIL excl_write1 got resp=%0d want 1", br);
        end
        d[0] = first ^ 16'h5A5A;
        do_write(2'd2, 16'h0020, 1, d, s, 1'b1, br, bi, lat, to);
        checks++;
        if (to || br !== RESP_OKAY) begin
            errors++; $display("FAIL excl_write2 got resp=%0d want 0", br);
        end
        do_read(2'd0, 16'h0020, 1'b0, rd, rr, ri, rl, lat, to);
        checks++;
        if (to || rd !== model_mem[16] || rr !== RESP_OKAY) begin
            errors++; $display("FAIL excl_mem got data=%h resp=%0d want %h 0", rd, rr, model_mem[16]);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.rd_req_i = '0; bus.rd_req_valid_i = 1'b0;
        bus.wr_req_i = '0; bus.wr_req_valid_i = 1'b0;
        bus.r_ready_i = 1'b0; bus.b_ready_i = 1'b0;
        test_reset();
        test_fill();
        test_basic();
        test_random();
        test_decerr();
        test_arbiter();
        test_reset_midburst();
`ifdef AXI_MEM_RESPONDER_EXCL_MON_EN
        test_exclusive();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 The module SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-002 The module SHALL use the axi_pkg types and widths: id 2b, addr 16b, data 16b, strb 2b, resp 2b.
REQ-003 The module SHALL have parameter BANK_ID, default 4'h0, meaning the addr[15:12] value this responder serves.
REQ-004 The module SHALL have parameter MEM_WORDS, default 2048, meaning the memory depth in 16-bit words, indexed by addr[11:1].
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 rd_req_i  in  rd_req_t  read request payload; rd_req_valid_i in 1; rd_req_ready_o out 1.
REQ-008 wr_req_i  in  wr_req_t  write beat payload; wr_req_valid_i in 1; wr_req_ready_o out 1.
REQ-009 r_id_o out 2, r_data_o out 16, r_resp_o out 2, r_last_o out 1, r_valid_o out 1, r_ready_i in 1: read response channel.
REQ-010 b_id_o out 2, b_resp_o out 2, b_valid_o out 1, b_ready_i in 1: write response channel.

Function
REQ-011 A transfer on any channel SHALL occur only on a clock edge where valid and ready are both 1.
REQ-012 Response codes SHALL be OKAY=0, EXOKAY=1, DECERR=3; SLVERR SHALL never be issued.
REQ-013 The FSM SHALL have four states: IDLE, WRITE (accepting burst beats), WR_RESP (B pending) and RD_RESP (R pending).
REQ-014 In IDLE, rd_req_ready_o and wr_req_ready_o SHALL be combinationally granted to at most one requester.
REQ-015 When only one requester is valid, that requester SHALL be granted.
REQ-016 When both requesters are valid, the grant SHALL alternate round-robin, starting with read after reset.
REQ-017 On an accepted read, the FSM SHALL go IDLE->RD_RESP.
REQ-018 r_valid_o SHALL assert on the next cycle with r_last_o=1 and r_id_o equal to the request id.
REQ-019 r_data_o SHALL equal mem[addr[11:1]] when bank_addr==BANK_ID; otherwise it SHALL be 16'h0000 with DECERR.
REQ-020 R outputs SHALL hold stable until r_ready_i; the handshake cycle SHALL return the FSM to IDLE.
REQ-021 On an accepted first write beat, the module SHALL capture id and the decode result and go to WRITE; if that beat has last=1, it SHALL go directly to WR_RESP.
REQ-022 In WRITE, wr_req_ready_o SHALL be 1 and rd_req_ready_o SHALL be 0.
REQ-023 Each beat SHALL write its own addr[11:1] word, byte lane i only where strb[i]=1.
REQ-024 A beat with last=1 SHALL move the FSM to WR_RESP.
REQ-025 If the first beat fails decode, no beat of that burst SHALL modify memory and b_resp_o SHALL be DECERR.
REQ-026 b_valid_o SHALL assert the cycle after the last beat is accepted, with the captured id, and SHALL hold until b_ready_i; the FSM SHALL then return to IDLE.
REQ-027 A read issued after a write's B handshake SHALL return the written data (no stale read).
REQ-028 Read data latency SHALL be exactly one cycle from request acceptance to r_valid_o.
REQ-029 Write response latency SHALL be exactly one cycle from last-beat acceptance to b_valid_o.

Reset
REQ-030 On rst=1 at a clock edge: FSM=IDLE, r_valid_o=0, b_valid_o=0, r_*/b_* payload outputs=0, round-robin pointer=read, exclusive reservation cleared.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 A reset during WRITE SHALL abandon the burst; beats already written SHALL remain in memory, and no B response SHALL be issued.

Configuration
REQ-033 Macro AXI_MEM_RESPONDER_EXCL_MON_EN SHALL compile in a single-entry exclusive monitor holding valid, id and word address.
REQ-034 With the macro defined, a decoded read with lock=1 SHALL set the reservation to {id, word} and return EXOKAY.
REQ-035 With the macro defined, an exclusive write SHALL succeed (write performed, EXOKAY, reservation cleared) only if its first beat matches the reservation id and word; otherwise all its beats SHALL be suppressed and B SHALL be OKAY.
REQ-036 With the macro defined, any performed non-exclusive write beat to the reserved word SHALL clear the reservation.
REQ-037 With the macro defined, DECERR SHALL take precedence over exclusive handling.
REQ-038 Without the macro, lock SHALL be ignored, all decoded responses SHALL be OKAY, and the module SHALL contain no monitor logic.

Verification
REQ-039 Write id=1, addr=0x0010, data=0xBEEF, strb=2'b11, last=1; B handshake -> b_resp=OKAY, b_id=1; then read addr=0x0010 -> r_data=0xBEEF one cycle after acceptance, r_last=1.
REQ-040 Write strb=2'b01, data=0x1234 over existing 0xBEEF -> a following read returns 0xBE34.
REQ-041 Read and write valid in the same cycle twice in succession -> first grant goes to read, second to write; with r_ready_i held at 0 for 5 cycles, r_valid_o stays 1 and the payload stays stable.
REQ-042 BANK_ID=0 with write addr=0x1010 (3-beat burst) -> memory unchanged, b_resp=DECERR; read addr=0x2000 -> r_data=0, r_resp=DECERR.
REQ-043 Macro defined: exclusive read id=2, addr=0x0020 -> EXOKAY; exclusive write id=2 to the same address -> EXOKAY and write performed; a second exclusive write -> OKAY and memory unchanged.
REQ-044 rst asserted after beat 2 of a 4-beat burst -> b_valid_o stays 0, FSM returns to IDLE, and beats 1-2 read back as written.
